// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: two-write/two-read register file with write-to-read bypass
// and a per-register pending-write scoreboard for RAW hazard detection.
module regfile_mp_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [AW-1:0]   rs1_i,
    input  logic [AW-1:0]   rs2_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic            rs1_busy_o,
    output logic            rs2_busy_o,
    input  logic            wa_en_i,
    input  logic [AW-1:0]   wa_addr_i,
    input  logic [XLEN-1:0] wa_data_i,
    input  logic            wb_en_i,
    input  logic [AW-1:0]   wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            issue_en_i,
    input  logic [AW-1:0]   issue_rd_i,
    input  logic            flush_i,
    output logic            wr_conflict_o
);
    localparam bit ZR = ZERO_REG != 0;
    localparam bit BP = BYPASS != 0;
    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] pend_q, pend_d;
    logic             conflict_q, conflict_d;
    logic             wa_ok, wb_ok, issue_ok;
    logic             a_hit1, b_hit1, a_hit2, b_hit2;
    // Accesses to a hardwired r0 are dropped here, so r0 is never written, bypassed or pending.
    assign wa_ok    = wa_en_i && !(ZR && wa_addr_i == '0);
    assign wb_ok    = wb_en_i && !(ZR && wb_addr_i == '0);
    assign issue_ok = issue_en_i && !(ZR && issue_rd_i == '0);
    assign conflict_d = wa_ok && wb_ok && wa_addr_i == wb_addr_i;
    assign a_hit1 = BP && wa_ok && wa_addr_i == rs1_i;
    assign b_hit1 = BP && wb_ok && wb_addr_i == rs1_i;
    assign a_hit2 = BP && wa_ok && wa_addr_i == rs2_i;
    assign b_hit2 = BP && wb_ok && wb_addr_i == rs2_i;
    assign rs1_data_o = a_hit1 ? wa_data_i : b_hit1 ? wb_data_i : regs_q[rs1_i];
    assign rs2_data_o = a_hit2 ? wa_data_i : b_hit2 ? wb_data_i : regs_q[rs2_i];
    assign rs1_busy_o = pend_q[rs1_i] && !(a_hit1 || b_hit1);
    assign rs2_busy_o = pend_q[rs2_i] && !(a_hit2 || b_hit2);
    assign wr_conflict_o = conflict_q;
    // A same-cycle issue outranks a completing write: the new producer owns the register.
    always_comb begin
        pend_d = pend_q;
        if (wa_ok) pend_d[wa_addr_i] = 1'b0;
        if (wb_ok) pend_d[wb_addr_i] = 1'b0;
        if (issue_ok) pend_d[issue_rd_i] = 1'b1;
        if (flush_i) pend_d = '0;
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            regs_q     <= '{default: '0};
            pend_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            if (wb_ok) regs_q[wb_addr_i] <= wb_data_i;
            if (wa_ok) regs_q[wa_addr_i] <= wa_data_i;
            pend_q     <= pend_d;
            conflict_q <= conflict_d;
        end
    end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: three configurations (default, no bypass, 64x16 without r0)
// checked every cycle against a behavioural model plus directed literal checks.
module tb_regfile_mp_sb;
    typedef struct packed {
        logic        wa_en;
        logic [4:0]  wa_addr;
        logic [63:0] wa_data;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [63:0] wb_data;
        logic        issue_en;
        logic [4:0]  issue_rd;
        logic        flush;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } stim_t;

    logic  clk = 0;
    logic  rst_n;
    stim_t s, p;
    int    n_cmp = 0, n_bad = 0;

    logic [31:0] d1_0, d2_0, d1_1, d2_1;
    logic [63:0] d1_2, d2_2;
    logic        b1_0, b2_0, c_0, b1_1, b2_1, c_1, b1_2, b2_2, c_2;

    always #5 clk = ~clk;

    regfile_mp_sb dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .rs1_i(s.rs1), .rs2_i(s.rs2),
        .rs1_data_o(d1_0), .rs2_data_o(d2_0), .rs1_busy_o(b1_0), .rs2_busy_o(b2_0),
        .wa_en_i(s.wa_en), .wa_addr_i(s.wa_addr), .wa_data_i(s.wa_data[31:0]),
        .wb_en_i(s.wb_en), .wb_addr_i(s.wb_addr), .wb_data_i(s.wb_data[31:0]),
        .issue_en_i(s.issue_en), .issue_rd_i(s.issue_rd), .flush_i(s.flush),
        .wr_conflict_o(c_0)
    );

    regfile_mp_sb #(.BYPASS(0)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .rs1_i(s.rs1), .rs2_i(s.rs2),
        .rs1_data_o(d1_1), .rs2_data_o(d2_1), .rs1_busy_o(b1_1), .rs2_busy_o(b2_1),
        .wa_en_i(s.wa_en), .wa_addr_i(s.wa_addr), .wa_data_i(s.wa_data[31:0]),
        .wb_en_i(s.wb_en), .wb_addr_i(s.wb_addr), .wb_data_i(s.wb_data[31:0]),
        .issue_en_i(s.issue_en), .issue_rd_i(s.issue_rd), .flush_i(s.flush),
        .wr_conflict_o(c_1)
    );

    regfile_mp_sb #(.XLEN(64), .NREGS(16), .ZERO_REG(0), .BYPASS(1)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .rs1_i(p.rs1[3:0]), .rs2_i(p.rs2[3:0]),
        .rs1_data_o(d1_2), .rs2_data_o(d2_2), .rs1_busy_o(b1_2), .rs2_busy_o(b2_2),
        .wa_en_i(p.wa_en), .wa_addr_i(p.wa_addr[3:0]), .wa_data_i(p.wa_data),
        .wb_en_i(p.wb_en), .wb_addr_i(p.wb_addr[3:0]), .wb_data_i(p.wb_data),
        .issue_en_i(p.issue_en), .issue_rd_i(p.issue_rd[3:0]), .flush_i(p.flush),
        .wr_conflict_o(c_2)
    );

    // Model state per configuration k: 0 = default, 1 = no bypass, 2 = 64-bit x 16 with ordinary r0
    logic [63:0] m_reg  [3][32];
    bit          m_pend [3][32];
    bit          m_conf [3];
    stim_t       mt, ct;

    function automatic bit zr(int k);
        return k != 2;
    endfunction

    function automatic bit byp(int k);
        return k != 1;
    endfunction

    function automatic bit wr_ok(int k, logic en, logic [4:0] a);
        return en && !(zr(k) && a == 0);
    endfunction

    function automatic bit hit(int k, stim_t t, logic [4:0] rs);
        return byp(k) && ((wr_ok(k, t.wa_en, t.wa_addr) && t.wa_addr == rs) ||
                          (wr_ok(k, t.wb_en, t.wb_addr) && t.wb_addr == rs));
    endfunction

    function automatic logic [63:0] exp_d(int k, stim_t t, logic [4:0] rs);
        logic [63:0] v;
        if (zr(k) && rs == 0) v = 0;
        else if (byp(k) && wr_ok(k, t.wa_en, t.wa_addr) && t.wa_addr == rs) v = t.wa_data;
        else if (byp(k) && wr_ok(k, t.wb_en, t.wb_addr) && t.wb_addr == rs) v = t.wb_data;
        else v = m_reg[k][rs];
        return k < 2 ? {32'b0, v[31:0]} : v;
    endfunction

    function automatic logic exp_b(int k, stim_t t, logic [4:0] rs);
        return m_pend[k][rs] && !hit(k, t, rs);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_conf[k] <= 0;
                for (int r = 0; r < 32; r++) begin
                    m_reg[k][r]  <= 0;
                    m_pend[k][r] <= 0;
                end
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                mt = k < 2 ? s : p;
                m_conf[k] <= wr_ok(k, mt.wa_en, mt.wa_addr) && wr_ok(k, mt.wb_en, mt.wb_addr)
                             && mt.wa_addr == mt.wb_addr;
                if (wr_ok(k, mt.wb_en, mt.wb_addr)) m_reg[k][mt.wb_addr] <= mt.wb_data;
                if (wr_ok(k, mt.wa_en, mt.wa_addr)) m_reg[k][mt.wa_addr] <= mt.wa_data;
                if (mt.flush) begin
                    for (int r = 0; r < 32; r++) m_pend[k][r] <= 0;
                end else begin
                    if (wr_ok(k, mt.wa_en, mt.wa_addr)) m_pend[k][mt.wa_addr] <= 0;
                    if (wr_ok(k, mt.wb_en, mt.wb_addr)) m_pend[k][mt.wb_addr] <= 0;
                    if (mt.issue_en && !(zr(k) && mt.issue_rd == 0)) m_pend[k][mt.issue_rd] <= 1;
                end
            end
        end
    end

    task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk(int k, stim_t t, logic [63:0] a1, logic [63:0] a2,
                       logic bb1, logic bb2, logic cc);
        cmp($sformatf("m%0d.rs1_data", k), a1, exp_d(k, t, t.rs1));
        cmp($sformatf("m%0d.rs2_data", k), a2, exp_d(k, t, t.rs2));
        cmp($sformatf("m%0d.rs1_busy", k), {63'b0, bb1}, {63'b0, exp_b(k, t, t.rs1)});
        cmp($sformatf("m%0d.rs2_busy", k), {63'b0, bb2}, {63'b0, exp_b(k, t, t.rs2)});
        cmp($sformatf("m%0d.conflict", k), {63'b0, cc}, {63'b0, m_conf[k]});
    endtask

    always @(negedge clk) begin
        ct = s;
        chk(0, ct, {32'b0, d1_0}, {32'b0, d2_0}, b1_0, b2_0, c_0);
        chk(1, ct, {32'b0, d1_1}, {32'b0, d2_1}, b1_1, b2_1, c_1);
        ct = p;
        chk(2, ct, d1_2, d2_2, b1_2, b2_2, c_2);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        s = '0;
        p = '0;
        rst_n = 1;
        #1 rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        s.wa_en = 1; s.wa_addr = 5; s.wa_data = 64'hDEADBEEF;
        tick;
        s = '0; s.rs1 = 5;
        #1 cmp("rst_pre_r5", {32'b0, d1_0}, 64'hDEADBEEF);
        rst_n = 0;
        #1 cmp("rst_async_r5", {32'b0, d1_0}, 64'h0);
        s.wa_en = 1; s.wa_addr = 5; s.wa_data = 64'h1111; s.issue_en = 1; s.issue_rd = 6;
        tick;
        s = '0; s.rs1 = 5; s.rs2 = 6; rst_n = 1;
        #1 cmp("rst_post_r5", {32'b0, d1_0}, 64'h0);
        cmp("rst_post_busy", {63'b0, b2_0}, 64'h0);
        cmp("rst_post_conf", {63'b0, c_0}, 64'h0);
        tick;

        s = '0; s.wa_en = 1; s.wa_addr = 7; s.wa_data = 64'h12345678; s.rs1 = 7;
        #1 cmp("byp_same", {32'b0, d1_0}, 64'h12345678);
        cmp("nobyp_same", {32'b0, d1_1}, 64'h0);
        tick;
        s = '0; s.rs1 = 7;
        #1 cmp("nobyp_next", {32'b0, d1_1}, 64'h12345678);
        tick;

        s = '0; s.wa_en = 1; s.wa_addr = 3; s.wa_data = 64'hAAAA0000;
        s.wb_en = 1; s.wb_addr = 3; s.wb_data = 64'h5555FFFF; s.rs1 = 3;
        #1 cmp("coll_byp_a", {32'b0, d1_0}, 64'hAAAA0000);
        cmp("coll_conf_pre", {63'b0, c_0}, 64'h0);
        tick;
        s = '0; s.rs1 = 3;
        #1 cmp("coll_conf", {63'b0, c_0}, 64'h1);
        cmp("coll_r3", {32'b0, d1_1}, 64'hAAAA0000);
        tick;
        #1 cmp("coll_conf_end", {63'b0, c_0}, 64'h0);
        tick;
        s = '0; s.wa_en = 1; s.wa_addr = 0; s.wa_data = 64'h1;
        s.wb_en = 1; s.wb_addr = 0; s.wb_data = 64'h2; s.rs1 = 0;
        #1 cmp("r0_byp", {32'b0, d1_0}, 64'h0);
        tick;
        s = '0;
        #1 cmp("r0_conf", {63'b0, c_0}, 64'h0);
        cmp("r0_read", {32'b0, d1_1}, 64'h0);
        tick;

        s = '0; s.issue_en = 1; s.issue_rd = 9; s.rs2 = 9;
        #1 cmp("sb_issue_same", {63'b0, b2_0}, 64'h0);
        tick;
        s = '0; s.rs2 = 9;
        #1 cmp("sb_pending", {63'b0, b2_0}, 64'h1);
        cmp("sb_pending_nb", {63'b0, b2_1}, 64'h1);
        tick;
        s = '0; s.wb_en = 1; s.wb_addr = 9; s.wb_data = 64'h99; s.rs2 = 9;
        #1 cmp("sb_wr_byp", {63'b0, b2_0}, 64'h0);
        cmp("sb_wr_nobyp", {63'b0, b2_1}, 64'h1);
        tick;
        s = '0; s.rs2 = 9;
        #1 cmp("sb_cleared", {63'b0, b2_1}, 64'h0);
        tick;
        s = '0; s.issue_en = 1; s.issue_rd = 9; s.wa_en = 1; s.wa_addr = 9; s.wa_data = 64'h77; s.rs2 = 9;
        tick;
        s = '0; s.rs2 = 9;
        #1 cmp("sb_issue_wins", {63'b0, b2_0}, 64'h1);
        tick;
        s = '0; s.issue_en = 1; s.issue_rd = 9; s.rs2 = 9;
        tick;
        s = '0; s.rs2 = 9; s.wb_en = 1; s.wb_addr = 9; s.wb_data = 64'h55;
        tick;
        s = '0; s.rs2 = 9;
        #1 cmp("sb_reissue_clr", {63'b0, b2_0}, 64'h0);
        cmp("sb_reissue_data", {32'b0, d2_1}, 64'h55);
        tick;

        for (int r = 1; r <= 3; r++) begin
            s = '0; s.issue_en = 1; s.issue_rd = 5'(r);
            tick;
        end
        s = '0; s.rs1 = 1; s.rs2 = 2;
        #1 cmp("fl_pre_r1", {63'b0, b1_0}, 64'h1);
        s.flush = 1; s.issue_en = 1; s.issue_rd = 4; s.wa_en = 1; s.wa_addr = 2; s.wa_data = 64'h1;
        tick;
        s = '0; s.rs1 = 1; s.rs2 = 2;
        #1 cmp("fl_r1", {63'b0, b1_0}, 64'h0);
        cmp("fl_r2", {63'b0, b2_0}, 64'h0);
        cmp("fl_r2_data", {32'b0, d2_0}, 64'h1);
        s.rs1 = 3; s.rs2 = 4;
        #1 cmp("fl_r3", {63'b0, b1_0}, 64'h0);
        cmp("fl_r4", {63'b0, b2_0}, 64'h0);
        tick;

        p = '0; p.wa_en = 1; p.wa_addr = 0; p.wa_data = 64'hFFFF_FFFF_FFFF_FFFF; p.rs1 = 0;
        #1 cmp("p_r0_byp", d1_2, 64'hFFFF_FFFF_FFFF_FFFF);
        tick;
        p = '0; p.rs1 = 0;
        #1 cmp("p_r0", d1_2, 64'hFFFF_FFFF_FFFF_FFFF);
        p.issue_en = 1; p.issue_rd = 15; p.rs2 = 15;
        tick;
        p = '0; p.rs2 = 15;
        #1 cmp("p_r15_busy", {63'b0, b2_2}, 64'h1);
        p.wb_en = 1; p.wb_addr = 15; p.wb_data = 64'h0123_4567_89AB_CDEF;
        #1 cmp("p_r15_byp_busy", {63'b0, b2_2}, 64'h0);
        tick;
        p = '0; p.rs2 = 15;
        #1 cmp("p_r15_clr", {63'b0, b2_2}, 64'h0);
        cmp("p_r15_data", d2_2, 64'h0123_4567_89AB_CDEF);
        tick;

        for (int i = 0; i < 300; i++) begin
            s.wa_en = 1'($urandom_range(0, 1));
            s.wa_addr = 5'($urandom_range(0, 7));
            s.wa_data = {32'b0, $urandom};
            s.wb_en = 1'($urandom_range(0, 1));
            s.wb_addr = 5'($urandom_range(0, 7));
            s.wb_data = {32'b0, $urandom};
            s.issue_en = 1'($urandom_range(0, 1));
            s.issue_rd = 5'($urandom_range(0, 7));
            s.flush = $urandom_range(0, 15) == 0;
            s.rs1 = 5'($urandom_range(0, 7));
            s.rs2 = 5'($urandom_range(0, 7));
            p.wa_en = 1'($urandom_range(0, 1));
            p.wa_addr = 5'($urandom_range(0, 15));
            p.wa_data = {$urandom, $urandom};
            p.wb_en = 1'($urandom_range(0, 1));
            p.wb_addr = 5'($urandom_range(0, 15));
            p.wb_data = {$urandom, $urandom};
            p.issue_en = 1'($urandom_range(0, 1));
            p.issue_rd = 5'($urandom_range(0, 15));
            p.flush = $urandom_range(0, 15) == 0;
            p.rs1 = 5'($urandom_range(0, 15));
            p.rs2 = 5'($urandom_range(0, 15));
            tick;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
